// File: rtl/spi_temp_sensor_mc_pkg.sv
// Shared types and constants for the multi-channel SPI temperature sensor.
package spi_temp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_e;

    localparam logic [15:0] RESET_VAL_DEF = 16'h0B9F;

    // Address bits per frame; a single channel still takes one address bit.
    function automatic int ch_width(input int n);
        if (n <= 1) return 1;
        return $clog2(n);
    endfunction

endpackage

// File: rtl/spi_temp_sensor_mc_sync.sv
// Two-flop synchronizer with registered rise/fall pulses for an SPI pin sampled on clk.
module spi_pin_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pin_i,
    output logic rise_o,
    output logic fall_o
);

    logic       meta_q;
    logic       sync_q;
    logic       prev_q;
    logic       rise_q;
    logic       fall_q;
    logic [2:0] arm_q;

    // arm_q hides the first real pin level after reset so a pin already
    // away from RST_VAL does not look like a fresh edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
            arm_q  <= '0;
        end else begin
            meta_q <= pin_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
            arm_q  <= {arm_q[1:0], 1'b1};
            rise_q <= arm_q[2] & sync_q & ~prev_q;
            fall_q <= arm_q[2] & ~sync_q & prev_q;
        end
    end

    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/spi_temp_sensor_mc.sv
// Multi-channel SPI mode-0 temperature slave: address in, selected word out MSB first.
//   state | meaning
//   IDLE  | deselected, sdo and sdo_oe low
//   ADDR  | shifting in CH_W address bits on sck rise
//   DATA  | shifting the selected word out on sck fall
module spi_temp_sensor_mc
    import spi_temp_pkg::*;
#(
    parameter int          DATA_W    = 16,
    parameter int          N_CH      = 4,
    parameter logic [15:0] RESET_VAL = RESET_VAL_DEF,
    parameter bit          BURST_EN  = 1'b1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [N_CH*DATA_W-1:0] temp_in,
    input  logic [N_CH-1:0]        temp_valid,
    input  logic                   cs_n,
    input  logic                   sck,
    input  logic                   sdi,
    output logic                   sdo,
    output logic                   sdo_oe,
    output logic                   busy,
    output logic                   word_done
);

    localparam int CH_W  = ch_width(N_CH);
    localparam int CNT_W = $clog2(((DATA_W > CH_W) ? DATA_W : CH_W) + 1);

    logic              cs_rise, cs_fall, sck_rise, sck_fall;
    logic              sdi_meta_q, sdi_sync_q;
    logic [DATA_W-1:0] hold_q [N_CH];

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CH_W-1:0]   addr_q, ch_q, ch_nxt;
    logic [DATA_W-1:0] shift_q, shift_sl, addr_word, ch_nxt_word;
    logic              spent_q, sdo_q, sdo_oe_q, busy_q, word_done_q;

    spi_pin_sync #(.RST_VAL(1'b1)) u_cs_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_i  (cs_n),
        .rise_o (cs_rise),
        .fall_o (cs_fall)
    );

    spi_pin_sync #(.RST_VAL(1'b0)) u_sck_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .pin_i  (sck),
        .rise_o (sck_rise),
        .fall_o (sck_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sdi_meta_q <= 1'b0;
            sdi_sync_q <= 1'b0;
        end else begin
            sdi_meta_q <= sdi;
            sdi_sync_q <= sdi_meta_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) hold_q[k] <= DATA_W'(RESET_VAL);
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (temp_valid[k]) hold_q[k] <= temp_in[k*DATA_W +: DATA_W];
            end
        end
    end

    // Out-of-range addresses fall through to the all-zero default.
    always_comb begin
        ch_nxt      = (ch_q == CH_W'(N_CH - 1)) ? '0 : ch_q + 1'b1;
        addr_word   = '0;
        ch_nxt_word = '0;
        for (int k = 0; k < N_CH; k++) begin
            if (addr_q == CH_W'(k)) addr_word = hold_q[k];
            if (ch_nxt == CH_W'(k)) ch_nxt_word = hold_q[k];
        end
    end

    assign shift_sl = shift_q << 1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            ch_q        <= '0;
            shift_q     <= '0;
            spent_q     <= 1'b0;
            sdo_q       <= 1'b0;
            sdo_oe_q    <= 1'b0;
            busy_q      <= 1'b0;
            word_done_q <= 1'b0;
        end else begin
            word_done_q <= 1'b0;
            if (cs_rise) begin
                state_q  <= IDLE;
                sdo_q    <= 1'b0;
                sdo_oe_q <= 1'b0;
                busy_q   <= 1'b0;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (cs_fall) begin
                            state_q  <= ADDR;
                            cnt_q    <= '0;
                            addr_q   <= '0;
                            spent_q  <= 1'b0;
                            sdo_q    <= 1'b0;
                            sdo_oe_q <= 1'b1;
                            busy_q   <= 1'b1;
                        end
                    end
                    ADDR: begin
                        if (sck_rise && cnt_q != CNT_W'(CH_W)) begin
                            addr_q <= CH_W'({addr_q, sdi_sync_q});
                            cnt_q  <= cnt_q + 1'b1;
                        end else if (sck_fall && cnt_q == CNT_W'(CH_W)) begin
                            shift_q <= addr_word;
                            sdo_q   <= addr_word[DATA_W-1];
                            ch_q    <= addr_q;
                            cnt_q   <= '0;
                            state_q <= DATA;
                        end
                    end
                    DATA: begin
                        if (sck_fall && !spent_q) begin
                            if (cnt_q != CNT_W'(DATA_W - 1)) begin
                                shift_q <= shift_sl;
                                sdo_q   <= shift_sl[DATA_W-1];
                                cnt_q   <= cnt_q + 1'b1;
                            end else begin
                                word_done_q <= 1'b1;
                                cnt_q       <= '0;
                                if (BURST_EN) begin
                                    ch_q    <= ch_nxt;
                                    shift_q <= ch_nxt_word;
                                    sdo_q   <= ch_nxt_word[DATA_W-1];
                                end else begin
                                    // Single-word frame: park on zero until deselect.
                                    shift_q <= '0;
                                    sdo_q   <= 1'b0;
                                    spent_q <= 1'b1;
                                end
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign sdo       = sdo_q;
    assign sdo_oe    = sdo_oe_q;
    assign busy      = busy_q;
    assign word_done = word_done_q;

endmodule
